aes_inv_key_gen: RTL and testbench

- Sequential inverse AES-128 key schedule for the decryption datapath of the AES-GCM core.
- Takes the final (round-10) key produced by the forward key generator and walks the schedule backwards, presenting round keys 10, 9, …, 0 one per beat on a valid/ready interface.
- The decrypt round pipeline consumes the keys in the order it needs them, so the full expanded schedule never has to be stored.

---
 rtl/aes_inv_key_gen.sv | 98 +++++++++
 tb/tb_aes_inv_key_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_gen.sv
// aes_inv_key_gen: walks the AES-128 key schedule backwards from the round-10 key.
//   i_clk, i_rst (async, active-high)
//   i_start, i_last_key : begin a walk from the given round-10 key (accepted only in IDLE)
//   i_ready             : consumer accepts the current beat
//   o_rnd_key, o_rnd_num, o_key_valid : round key 10..0 and its index
//   o_busy, o_done      : walk in progress / one-cycle completion pulse
module aes_inv_key_gen #(
    parameter int NUM_RNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_last_key,
    input  logic         i_ready,
    output logic [127:0] o_rnd_key,
    output logic [3:0]   o_rnd_num,
    output logic         o_key_valid,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [7:0] INV_EXP = 8'hfe;

    state_t       state, nxt;
    logic [127:0] key_r;
    logic [3:0]   rnd_r;
    logic         emit;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p ^= b[i] ? x : 8'h00;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return (r == 4'd9) ? 8'h1b : (r == 4'd10) ? 8'h36 : 8'(8'd1 << (r - 4'd1));
    endfunction

    // Undo one forward expansion step: recover the previous round's words from round r
    function automatic logic [127:0] inv_round(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] p0, p1, p2, p3, t;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        t  = {p3[23:0], p3[31:24]};
        p0 = k[127:96] ^ {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(r), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (i_start ? EMIT : IDLE) :
              (state == EMIT) ? ((i_ready && rnd_r == 4'd0) ? DONE : EMIT) : IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_r <= '0;
            rnd_r <= '0;
        end else if (state == IDLE && i_start) begin
            key_r <= i_last_key;
            rnd_r <= 4'(NUM_RNDS);
        end else if (state == EMIT && i_ready && rnd_r != 4'd0) begin
            key_r <= inv_round(key_r, rnd_r);
            rnd_r <= rnd_r - 4'd1;
        end
    end

    always_comb begin
        emit        = state == EMIT;
        o_key_valid = emit;
        o_busy      = emit;
        o_done      = state == DONE;
        o_rnd_key   = emit ? key_r : '0;
        o_rnd_num   = emit ? rnd_r : '0;
    end
endmodule

// File: tb/tb_aes_inv_key_gen.sv
// tb_aes_inv_key_gen: directed + random checks of the inverse key walk against a forward-expansion model.
module tb_aes_inv_key_gen;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic         ready = 1'b1;
    logic [127:0] rnd_key;
    logic [3:0]   rnd_num;
    logic         key_valid, busy, done;

    int n_assert = 0;
    int n_fail = 0;
    int cyc;

    logic [127:0] rk  [0:10];
    logic [127:0] got [0:10];
    logic [7:0]   rcon_tb [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [2047:0] sbox_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_inv_key_gen #(.NUM_RNDS(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_last_key(last_key), .i_ready(ready),
        .o_rnd_key(rnd_key), .o_rnd_num(rnd_num), .o_key_valid(key_valid), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tbl[2047 - 8 * int'(x) -: 8];
    endfunction

    // Forward FIPS-197 expansion; rk[r] is the round-r key
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon_tb[i / 4], 24'h0};
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_beat(input string tag, input int r);
        chk({tag, "_valid"}, 128'(key_valid), 128'd1);
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_num"}, 128'(rnd_num), 128'(r));
        chk({tag, "_key"}, rnd_key, rk[r]);
    endtask

    // Walk from the round-10 key of seed; stalls at rnd 7 / rnd 0; optional ignored starts
    task automatic walk(input logic [127:0] seed, input int s7, input int s0, input bit inject);
        expand(seed);
        last_key = rk[10];
        start = 1'b1;
        ready = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            for (int s = 0; s < ((r == 7) ? s7 : (r == 0) ? s0 : 0); s++) begin
                ready = 1'b0;
                chk_beat("stall", r);
                step();
            end
            ready = 1'b1;
            if (inject && r == 5) begin
                start = 1'b1;
                last_key = {$urandom, $urandom, $urandom, $urandom};
            end
            chk_beat("beat", r);
            got[r] = rnd_key;
            step();
            start = 1'b0;
        end
        chk("done_pulse", 128'(done), 128'd1);
        chk("done_valid", 128'(key_valid), 128'd0);
        chk("done_busy", 128'(busy), 128'd0);
        chk("done_latency", 128'(cyc), 128'(12 + s7 + s0));
        if (inject) begin
            start = 1'b1;
            last_key = {$urandom, $urandom, $urandom, $urandom};
        end
        step();
        start = 1'b0;
        chk("after_done", 128'(done), 128'd0);
        chk("after_valid", 128'(key_valid), 128'd0);
    endtask

    initial begin
        #2;
        chk("rst_key", rnd_key, 128'd0);
        chk("rst_num", 128'(rnd_num), 128'd0);
        chk("rst_valid", 128'(key_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        step();
        rst = 1'b0;
        step();

        walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 1'b0);
        chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 3, 1, 1'b0);
        chk("bp_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 1'b1);
        chk("inj_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        last_key = rk[10];
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_num", 128'(rnd_num), 128'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_key", rnd_key, 128'd0);
        chk("arst_num", 128'(rnd_num), 128'd0);
        chk("arst_valid", 128'(key_valid), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_done", 128'(done), 128'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_done", 128'(done), 128'd0);
        chk("post_rst_valid", 128'(key_valid), 128'd0);

        walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 1'b0);
        chk("rst_walk_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        for (int n = 0; n < 20; n++) walk({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
